// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and helpers for the vector add/sub datapath.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF     = 32'h7F800000;
  localparam int unsigned FP32_EXP_BIAS = 127;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned ALIGN_W = 27;  // hidden + 23 frac + guard/round/sticky
  localparam int unsigned SUM_W   = 28;  // ALIGN_W plus carry-out
  localparam int unsigned LZC_W   = 5;
  localparam int unsigned NEXP_W  = 10;  // headroom for carry and rounding increments

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  // Unpacked, swapped and aligned operands.
  typedef struct packed {
    logic               spec;
    logic [31:0]        spec_val;
    logic               sx;
    logic               sy;
    logic               zsign;
    logic [EXP_W-1:0]   ex;
    logic [ALIGN_W-1:0] mx;
    logic [ALIGN_W-1:0] my;
  } s1_t;

  // Raw mantissa sum ahead of normalization.
  typedef struct packed {
    logic             spec;
    logic [31:0]      spec_val;
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] ex;
    logic [SUM_W-1:0] sum;
  } s2_t;

  // Denormals classify as ZERO so they flush to signed zero.
  function automatic fp_class_e fp_classify(input fp32_t v);
    if (v.exp == 8'hFF) return (v.mant != '0) ? NAN : INF;
    if (v.exp == 8'h00) return ZERO;
    return NORM;
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Leading-zero counter over the 28-bit mantissa sum; all-zero input yields 28.
module fp32_lzc
  import fp32_pkg::*;
(
  input  logic [SUM_W-1:0] data,
  output logic [LZC_W-1:0] count
);

  // Highest set bit wins since later iterations overwrite earlier ones.
  always_comb begin
    count = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (data[i]) count = LZC_W'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_addsub_pipe.sv
// Three-stage binary32 adder/subtractor (RNE, flush-to-zero) with a
// valid/ready handshake; back-pressure freezes every stage together.
module fp32_addsub_pipe
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic adv;
  logic v1_q, v2_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, swap, align ----------------
  fp32_t             a, b, x, y;
  fp_class_e         ca, cb;
  logic              swap;
  logic [EXP_W-1:0]  d;
  logic [23:0]       mx24, my24;
  logic [ALIGN_W-1:0] f, mask;

  always_comb begin
    a        = in_a;
    b        = in_b;
    b.sign   = in_b[31] ^ in_sub;
    ca       = fp_classify(a);
    cb       = fp_classify(b);
    if (ca == ZERO) begin
      a.exp  = '0;
      a.mant = '0;
    end
    if (cb == ZERO) begin
      b.exp  = '0;
      b.mant = '0;
    end
    swap     = {b.exp, b.mant} > {a.exp, a.mant};
    x        = swap ? b : a;
    y        = swap ? a : b;
    mx24     = {x.exp != '0, x.mant};
    my24     = {y.exp != '0, y.mant};
    d        = x.exp - y.exp;
    f        = {my24, 3'b000};
    mask     = '0;

    s1_d          = '0;
    s1_d.sx       = x.sign;
    s1_d.sy       = y.sign;
    s1_d.ex       = x.exp;
    s1_d.zsign    = (ca == ZERO) & (cb == ZERO) & a.sign & b.sign;
    s1_d.mx       = {mx24, 3'b000};
    if (d >= 8'd27) begin
      s1_d.my = {26'b0, |my24};
    end else begin
      mask    = (ALIGN_W'(1) << d[4:0]) - ALIGN_W'(1);
      s1_d.my = (f >> d[4:0]) | {26'b0, |(f & mask)};
    end

    // Specials bypass the arithmetic but ride the same pipe.
    if (ca == NAN || cb == NAN) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = FP32_QNAN;
    end else if (ca == INF && cb == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = (a.sign != b.sign) ? FP32_QNAN : {a.sign, FP32_PINF[30:0]};
    end else if (ca == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {a.sign, FP32_PINF[30:0]};
    end else if (cb == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {b.sign, FP32_PINF[30:0]};
    end
  end

  // ---------------- S2: mantissa add / subtract ----------------
  always_comb begin
    s2_d          = '0;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sx;
    s2_d.zsign    = s1_q.zsign;
    s2_d.ex       = s1_q.ex;
    if (s1_q.sx ^ s1_q.sy) s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
    else                   s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [LZC_W-1:0]   lz;
  logic [NEXP_W-1:0]  e3, need, sh;
  logic [ALIGN_W-1:0] norm;
  logic               up;
  logic [24:0]        mant25;
  logic [FRAC_W-1:0]  frac;
  logic [31:0]        res_d;

  fp32_lzc u_lzc (
    .data  (s2_q.sum),
    .count (lz)
  );

  always_comb begin
    e3     = {2'b00, s2_q.ex};
    need   = NEXP_W'(lz) - NEXP_W'(1);
    sh     = '0;
    norm   = '0;
    frac   = '0;
    res_d  = '0;
    if (s2_q.sum[SUM_W-1]) begin
      norm = {s2_q.sum[27:2], |s2_q.sum[1:0]};
      e3   = e3 + NEXP_W'(1);
    end else begin
      // Cap the shift so the exponent never drops below 1.
      sh   = (need > e3 - NEXP_W'(1)) ? e3 - NEXP_W'(1) : need;
      norm = s2_q.sum[ALIGN_W-1:0] << sh;
      e3   = e3 - sh;
    end
    up     = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant25 = {1'b0, norm[26:3]} + 25'(up);
    if (mant25[24]) begin
      e3   = e3 + NEXP_W'(1);
      frac = mant25[23:1];
    end else begin
      frac = mant25[22:0];
    end

    if (s2_q.spec)                res_d = s2_q.spec_val;
    else if (s2_q.sum == '0)      res_d = {s2_q.zsign, 31'h0};
    else if (!norm[ALIGN_W-1])    res_d = {s2_q.sign, 31'h0};
    else if (e3 >= NEXP_W'(255))  res_d = {s2_q.sign, FP32_PINF[30:0]};
    else if (e3 == '0)            res_d = {s2_q.sign, 31'h0};
    else                          res_d = {s2_q.sign, e3[7:0], frac};
  end

  // Pipeline registers; all stages move only on adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      s1_q      <= s1_d;
      v2_q      <= v1_q;
      s2_q      <= s2_d;
      out_valid <= v2_q;
      if (v2_q) out_data <= res_d;
    end
  end

endmodule
